// File: rtl/pong_pixel_core_if.sv
// Pixel-side bundle of pong_pixel_core: controls and scan position in, colour and game status out.
// The master drives the scan position and controls; the slave is the pixel core.
interface pong_pixel_core_if;
    logic        up;
    logic        down;
    logic        serve;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic [7:0]  score;
    logic [3:0]  lives_left;
    logic        game_over;

    modport master (
        output up, down, serve, video_on, x, y,
        input  rgb, score, lives_left, game_over
    );

    modport slave (
        input  up, down, serve, video_on, x, y,
        output rgb, score, lives_left, game_over
    );
endinterface

// File: rtl/pong_pixel_core.sv
// Single-player pong: game FSM, ball/paddle movement on the frame tick, and registered BGR pixel colour.
// Define PONG_ROUND_BALL_EN to draw a round ball; collision always uses the square bounding box.
module pong_pixel_core #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int WALL_X_L     = 77,
    parameter int WALL_X_R     = 84,
    parameter int PAD_X_L      = 620,
    parameter int PAD_X_R      = 624,
    parameter int PAD_HEIGHT   = 98,
    parameter int PAD_VELOCITY = 2,
    parameter int BALL_SIZE    = 12,
    parameter int BALL_VY      = 1,
    parameter int SPEED_INIT   = 2,
    parameter int SPEED_MAX    = 8,
    parameter int LIVES        = 3,
    parameter int MISS_FRAMES  = 30
) (
    input logic              clk,
    input logic              reset_n,
    pong_pixel_core_if.slave bus
);

    typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_MISS, ST_OVER} gameState_t;

    localparam logic [9:0] SERVE_X    = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] SERVE_Y    = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] PAD_T_INIT = 10'((V_ACTIVE - PAD_HEIGHT) / 2);
    localparam logic [9:0] BALL_Y_MAX = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] HIT_X      = 10'(PAD_X_L - BALL_SIZE);
    localparam logic [9:0] WALL_EDGE  = 10'(WALL_X_R + 1);
    localparam logic [9:0] VY         = 10'(BALL_VY);
    localparam logic [9:0] PAD_V      = 10'(PAD_VELOCITY);
    localparam logic [3:0] SPEED_LO   = 4'(SPEED_INIT);
    localparam logic [3:0] SPEED_HI   = 4'(SPEED_MAX);
    localparam logic [3:0] LIVES_INIT = 4'(LIVES);
    localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);

    gameState_t  state_q, state_d;
    logic [9:0]  ballX_q, ballX_d, ballY_q, ballY_d, padTop_q, padTop_d;
    logic        dirR_q, dirR_d, dirD_q, dirD_d;
    logic [3:0]  speed_q, speed_d, lives_q, lives_d;
    logic [7:0]  score_q, score_d, missCnt_q, missCnt_d;
    logic [11:0] rgb_q, rgb_d;

    logic        tick, hitEvent, missEvent, wallEvent;
    logic [10:0] ballRight, ballBottom, padBottom, reachRight;
    logic        ballShown, gameOver;
    logic [11:0] background;
    logic        onWall, onPaddle, inBox, ballPixel;

    assign tick       = (bus.y == 10'(V_ACTIVE + 1)) && (bus.x == 10'd0);
    assign ballRight  = 11'(ballX_q) + 11'(BALL_SIZE - 1);
    assign ballBottom = 11'(ballY_q) + 11'(BALL_SIZE - 1);
    assign padBottom  = 11'(padTop_q) + 11'(PAD_HEIGHT - 1);
    assign reachRight = ballRight + 11'(speed_q);

    // Horizontal events in priority order: paddle hit beats miss; the wall only matters moving left.
    assign hitEvent  = dirR_q && (ballRight < 11'(PAD_X_L)) && (reachRight >= 11'(PAD_X_L))
                       && (ballBottom >= 11'(padTop_q)) && (11'(ballY_q) <= padBottom);
    assign missEvent = dirR_q && !hitEvent && (reachRight >= 11'(H_ACTIVE - 1));
    assign wallEvent = !dirR_q && (11'(ballX_q) < 11'(WALL_EDGE) + 11'(speed_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SERVE;
            ballX_q   <= SERVE_X;
            ballY_q   <= SERVE_Y;
            dirR_q    <= 1'b1;
            dirD_q    <= 1'b1;
            speed_q   <= SPEED_LO;
            padTop_q  <= PAD_T_INIT;
            score_q   <= 8'd0;
            lives_q   <= LIVES_INIT;
            missCnt_q <= 8'd0;
            rgb_q     <= 12'h000;
        end else begin
            state_q   <= state_d;
            ballX_q   <= ballX_d;
            ballY_q   <= ballY_d;
            dirR_q    <= dirR_d;
            dirD_q    <= dirD_d;
            speed_q   <= speed_d;
            padTop_q  <= padTop_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            missCnt_q <= missCnt_d;
            rgb_q     <= rgb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SERVE: if (bus.serve) state_d = ST_PLAY;
            ST_PLAY:  if (tick && missEvent) state_d = (lives_q == 4'd1) ? ST_OVER : ST_MISS;
            ST_MISS:  if (tick && (missCnt_q == MISS_LAST)) state_d = ST_SERVE;
            ST_OVER:  if (bus.serve) state_d = ST_SERVE;
            default:  state_d = ST_SERVE;
        endcase
    end

    always_comb begin
        ballShown  = 1'b0;
        gameOver   = 1'b0;
        background = 12'hCCC;
        case (state_q)
            ST_SERVE, ST_PLAY: ballShown = 1'b1;
            ST_MISS:  background = 12'h00F;
            ST_OVER: begin
                gameOver   = 1'b1;
                background = 12'h444;
            end
            default: background = 12'hCCC;
        endcase
    end

    always_comb begin
        ballX_d   = ballX_q;
        ballY_d   = ballY_q;
        dirR_d    = dirR_q;
        dirD_d    = dirD_q;
        speed_d   = speed_q;
        padTop_d  = padTop_q;
        score_d   = score_q;
        lives_d   = lives_q;
        missCnt_d = 8'd0;
        if (state_q == ST_PLAY && tick) begin
            if (!dirD_q && (ballY_q < VY)) begin
                ballY_d = 10'd0;
                dirD_d  = 1'b1;
            end else if (dirD_q && (ballBottom + 11'(BALL_VY) > 11'(V_ACTIVE - 1))) begin
                ballY_d = BALL_Y_MAX;
                dirD_d  = 1'b0;
            end else begin
                ballY_d = dirD_q ? ballY_q + VY : ballY_q - VY;
            end
            if (hitEvent) begin
                ballX_d = HIT_X;
                dirR_d  = 1'b0;
                if (speed_q < SPEED_HI) speed_d = speed_q + 4'd1;
                if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end else if (missEvent) begin
                lives_d = lives_q - 4'd1;
            end else if (wallEvent) begin
                ballX_d = WALL_EDGE;
                dirR_d  = 1'b1;
            end else begin
                ballX_d = dirR_q ? ballX_q + 10'(speed_q) : ballX_q - 10'(speed_q);
            end
        end
        if (state_q == ST_MISS) begin
            if (!tick) missCnt_d = missCnt_q;
            else if (missCnt_q != MISS_LAST) missCnt_d = missCnt_q + 8'd1;
        end
        // Every way back into SERVE restores the launch conditions of a fresh ball.
        if (state_q != ST_SERVE && state_d == ST_SERVE) begin
            ballX_d = SERVE_X;
            ballY_d = SERVE_Y;
            dirR_d  = 1'b1;
            dirD_d  = 1'b1;
            speed_d = SPEED_LO;
        end
        if (state_q == ST_OVER && bus.serve) begin
            score_d = 8'd0;
            lives_d = LIVES_INIT;
        end
        if (tick && state_q != ST_OVER) begin
            if (bus.up) begin
                if (padTop_q >= PAD_V) padTop_d = padTop_q - PAD_V;
            end else if (bus.down) begin
                if (padBottom + 11'(PAD_VELOCITY) <= 11'(V_ACTIVE - 1)) padTop_d = padTop_q + PAD_V;
            end
        end
    end

    assign onWall   = (bus.x >= 10'(WALL_X_L)) && (bus.x <= 10'(WALL_X_R));
    assign onPaddle = (bus.x >= 10'(PAD_X_L)) && (bus.x <= 10'(PAD_X_R))
                      && (bus.y >= padTop_q) && (11'(bus.y) <= padBottom);
    assign inBox    = (bus.x >= ballX_q) && (11'(bus.x) <= ballRight)
                      && (bus.y >= ballY_q) && (11'(bus.y) <= ballBottom);

`ifdef PONG_ROUND_BALL_EN
    // Offsets are doubled so the circle centre lands on a pixel corner for even sizes.
    logic [9:0]  dx, dy;
    logic [11:0] twoDx, twoDy, offX, offY, sqX, sqY;
    logic [12:0] radSum;
    assign dx        = bus.x - ballX_q;
    assign dy        = bus.y - ballY_q;
    assign twoDx     = {1'b0, dx, 1'b1};
    assign twoDy     = {1'b0, dy, 1'b1};
    assign offX      = (twoDx >= 12'(BALL_SIZE)) ? twoDx - 12'(BALL_SIZE) : 12'(BALL_SIZE) - twoDx;
    assign offY      = (twoDy >= 12'(BALL_SIZE)) ? twoDy - 12'(BALL_SIZE) : 12'(BALL_SIZE) - twoDy;
    assign sqX       = offX * offX;
    assign sqY       = offY * offY;
    assign radSum    = {1'b0, sqX} + {1'b0, sqY};
    assign ballPixel = inBox && (radSum <= 13'(BALL_SIZE * BALL_SIZE));
`else
    assign ballPixel = inBox;
`endif

    always_comb begin
        rgb_d = background;
        if (!bus.video_on) rgb_d = 12'h000;
        else if (onWall || onPaddle) rgb_d = 12'h111;
        else if (ballShown && ballPixel) rgb_d = 12'h1FF;
    end

    assign bus.rgb        = rgb_q;
    assign bus.score      = score_q;
    assign bus.lives_left = lives_q;
    assign bus.game_over  = gameOver;

endmodule

// File: tb/tb_pong_pixel_core.sv
// Randomised scoreboard bench for pong_pixel_core: a frame-level game model predicts colour and status.
// Frames are compressed to a handful of probe pixels plus the tick pixel.
module tb_pong_pixel_core;

    localparam int H = 640, V = 480, BALL = 12;
    localparam int SERVE_X = 314, SERVE_Y = 234, PAD_INIT = 191, PAD_H = 98;
    localparam int M_SERVE = 0, M_PLAY = 1, M_MISS = 2, M_OVER = 3;

    typedef struct {
        logic [11:0] rgb;
        int          score;
        int          lives;
        bit          over;
    } expect_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    pong_pixel_core_if pif();

    pong_pixel_core dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (pif)
    );

    always #5 clk = ~clk;

    expect_t sbQ[$];
    int compared = 0;
    int mismatched = 0;

    int mMode, bx, by, bdr, bdd, bspd, padT, mScore, mLives, missCnt;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic serveBall();
        bx = SERVE_X; by = SERVE_Y; bdr = 1; bdd = 1; bspd = 2;
    endtask

    task automatic modelReset();
        mMode = M_SERVE; serveBall(); padT = PAD_INIT;
        mScore = 0; mLives = 3; missCnt = 0;
    endtask

    function automatic bit ballCovers(input int px, input int py);
        int dx, dy;
        dx = px - bx;
        dy = py - by;
        if (dx < 0 || dx >= BALL || dy < 0 || dy >= BALL) return 1'b0;
`ifdef PONG_ROUND_BALL_EN
        return ((2*dx - BALL + 1) * (2*dx - BALL + 1) + (2*dy - BALL + 1) * (2*dy - BALL + 1)) <= BALL * BALL;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [11:0] modelColour(input int px, input int py, input bit von);
        if (!von) return 12'h000;
        if (px >= 77 && px <= 84) return 12'h111;
        if (px >= 620 && px <= 624 && py >= padT && py <= padT + PAD_H - 1) return 12'h111;
        if ((mMode == M_SERVE || mMode == M_PLAY) && ballCovers(px, py)) return 12'h1FF;
        if (mMode == M_MISS) return 12'h00F;
        if (mMode == M_OVER) return 12'h444;
        return 12'hCCC;
    endfunction

    // One clock of game rules; collision sees the paddle as it was before this tick.
    task automatic modelStep(input bit up, input bit down, input bit serve, input bit tick);
        int oldMode = mMode;
        int oldPad = padT;
        int xr = bx + BALL - 1;
        int yb = by + BALL - 1;
        int yt = by;
        case (mMode)
            M_SERVE: if (serve) mMode = M_PLAY;
            M_PLAY: if (tick) begin
                if (bdd == 0 && by < 1) begin by = 0; bdd = 1; end
                else if (bdd == 1 && yb + 1 > V - 1) begin by = V - BALL; bdd = 0; end
                else by = by + (bdd ? 1 : -1);
                if (bdr == 1 && xr < 620 && xr + bspd >= 620 && yb >= oldPad && yt <= oldPad + PAD_H - 1) begin
                    bx = 620 - BALL; bdr = 0;
                    bspd = (bspd + 1 > 8) ? 8 : bspd + 1;
                    mScore = (mScore + 1 > 255) ? 255 : mScore + 1;
                end else if (bdr == 1 && xr + bspd >= H - 1) begin
                    mLives--;
                    if (mLives == 0) mMode = M_OVER;
                    else begin mMode = M_MISS; missCnt = 0; end
                end else if (bdr == 0 && bx < 85 + bspd) begin
                    bx = 85; bdr = 1;
                end else bx = bx + (bdr ? bspd : -bspd);
            end
            M_MISS: if (tick) begin
                missCnt++;
                if (missCnt == 30) begin serveBall(); mMode = M_SERVE; end
            end
            default: if (serve) begin
                mScore = 0; mLives = 3; serveBall(); mMode = M_SERVE;
            end
        endcase
        if (tick && oldMode != M_OVER) begin
            if (up) begin
                if (padT >= 2) padT -= 2;
            end else if (down) begin
                if (padT + PAD_H - 1 + 2 <= V - 1) padT += 2;
            end
        end
    endtask

    task automatic applyStimulus(input bit up, input bit down, input bit serve, input bit von,
                                 input int px, input int py);
        expect_t e;
        @(negedge clk);
        pif.up = up; pif.down = down; pif.serve = serve; pif.video_on = von;
        pif.x = 10'(px); pif.y = 10'(py);
        e.rgb = modelColour(px, py, von);
        modelStep(up, down, serve, (px == 0) && (py == V + 1));
        e.score = mScore; e.lives = mLives; e.over = (mMode == M_OVER);
        sbQ.push_back(e);
    endtask

    function automatic int clampX(input int v);
        return (v < 0) ? 0 : (v > H - 1) ? H - 1 : v;
    endfunction

    function automatic int clampY(input int v);
        return (v < 0) ? 0 : (v > V - 1) ? V - 1 : v;
    endfunction

    task automatic pickPixel(output int px, output int py, output bit von);
        int kind = $urandom_range(0, 5);
        von = 1'b1;
        case (kind)
            0: begin px = $urandom_range(0, H - 1); py = $urandom_range(0, V - 1); end
            1: begin px = clampX(bx + $urandom_range(0, 15) - 2); py = clampY(by + $urandom_range(0, 15) - 2); end
            2: begin px = 618 + $urandom_range(0, 8); py = clampY(padT + ($urandom_range(0, 1) ? PAD_H : 0) + $urandom_range(0, 3) - 2); end
            3: begin px = 75 + $urandom_range(0, 11); py = $urandom_range(0, V - 1); end
            4: begin px = $urandom_range(0, H - 1); py = $urandom_range(0, V - 1); von = 1'b0; end
            default: begin px = 320; py = 240; end
        endcase
    endtask

    // Paddle modes: 0 idle, 1 up, 2 down, 3 follow the ball, 4 random.
    task automatic runFrame(input int padMode, input bit serveOn);
        bit up = 1'b0, down = 1'b0, serve;
        int px, py;
        bit von;
        case (padMode)
            1: up = 1'b1;
            2: down = 1'b1;
            3: begin
                if (padT + 49 > by + 8) up = 1'b1;
                else if (padT + 49 + 2 < by + 6) down = 1'b1;
            end
            4: begin up = 1'($urandom_range(0, 1)); down = 1'($urandom_range(0, 1)); end
            default: ;
        endcase
        for (int i = 0; i < 5; i++) begin
            pickPixel(px, py, von);
            serve = serveOn && ($urandom_range(0, 7) == 0);
            applyStimulus(up, down, serve, von, px, py);
        end
        serve = serveOn && ($urandom_range(0, 7) == 0);
        applyStimulus(up, down, serve, 1'b0, 0, V + 1);
    endtask

    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("rgb", int'(pif.rgb), int'(e.rgb));
                checkOutput("score", int'(pif.score), e.score);
                checkOutput("lives_left", int'(pif.lives_left), e.lives);
                checkOutput("game_over", int'(pif.game_over), int'(e.over));
            end
        end
    end

    initial begin
        pif.up = 1'b0; pif.down = 1'b0; pif.serve = 1'b0;
        pif.video_on = 1'b1; pif.x = 10'd320; pif.y = 10'd240;
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_rgb", int'(pif.rgb), 0);
        checkOutput("reset_score", int'(pif.score), 0);
        checkOutput("reset_lives", int'(pif.lives_left), 3);
        checkOutput("reset_over", int'(pif.game_over), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int f = 0; f < 3; f++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 320, 240);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 100, 300);
            runFrame(0, 1'b0);
        end
        for (int f = 0; f < 120; f++) runFrame(1, 1'b0);
        for (int f = 0; f < 240; f++) runFrame(2, 1'b0);

        for (int f = 0; f < 2700; f++) begin
            case ((f / 300) % 3)
                0: runFrame(3, 1'b1);
                1: runFrame(4, 1'b1);
                default: runFrame(1, 1'b1);
            endcase
        end

        for (int k = 0; k < 8 && mMode != M_PLAY; k++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5, 5);
        for (int f = 0; f < 3; f++) runFrame(3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, bx + 6, by + 6);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rgb", int'(pif.rgb), 0);
        checkOutput("async_score", int'(pif.score), 0);
        checkOutput("async_lives", int'(pif.lives_left), 3);
        checkOutput("async_over", int'(pif.game_over), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
        for (int f = 0; f < 40; f++) runFrame(3, 1'b1);

        repeat (2) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
